// File: rtl/timer_pkg.sv
// Shared types and constants for the two-digit BCD countdown timer.
package timer_pkg;

    typedef enum logic [1:0] {IDLE, RUN, PAUSED, DONE} timer_state_t;

    localparam logic [3:0] BCD_MAX = 4'd9;

    // Active-high segment codes, bit order {g,f,e,d,c,b,a}
    localparam logic [6:0] SEG_0     = 7'b0111111;
    localparam logic [6:0] SEG_1     = 7'b0000110;
    localparam logic [6:0] SEG_2     = 7'b1011011;
    localparam logic [6:0] SEG_3     = 7'b1001111;
    localparam logic [6:0] SEG_4     = 7'b1100110;
    localparam logic [6:0] SEG_5     = 7'b1101101;
    localparam logic [6:0] SEG_6     = 7'b1111101;
    localparam logic [6:0] SEG_7     = 7'b0000111;
    localparam logic [6:0] SEG_8     = 7'b1111111;
    localparam logic [6:0] SEG_9     = 7'b1101111;
    localparam logic [6:0] SEG_BLANK = 7'b0000000;

    function automatic logic [3:0] bcd_clamp(input logic [3:0] digit);
        return (digit > BCD_MAX) ? BCD_MAX : digit;
    endfunction

endpackage

// File: rtl/bcd_to_7seg.sv
// Combinational BCD to 7-segment decoder; non-BCD codes are blanked.
module bcd_to_7seg
    import timer_pkg::*;
#(
    parameter bit SEG_ACTIVE_LOW = 1'b1
) (
    input  logic [3:0] bcd,
    output logic [6:0] seg
);

    logic [6:0] seg_high;

    always_comb begin
        seg_high = SEG_BLANK;
        case (bcd)
            4'd0:    seg_high = SEG_0;
            4'd1:    seg_high = SEG_1;
            4'd2:    seg_high = SEG_2;
            4'd3:    seg_high = SEG_3;
            4'd4:    seg_high = SEG_4;
            4'd5:    seg_high = SEG_5;
            4'd6:    seg_high = SEG_6;
            4'd7:    seg_high = SEG_7;
            4'd8:    seg_high = SEG_8;
            4'd9:    seg_high = SEG_9;
            default: seg_high = SEG_BLANK;
        endcase
    end

    assign seg = SEG_ACTIVE_LOW ? ~seg_high : seg_high;

endmodule

// File: rtl/tick_countdown_timer.sv
// Two-digit BCD countdown timer driven by rising edges of a divided slow clock.
module tick_countdown_timer
    import timer_pkg::*;
#(
    parameter bit SEG_ACTIVE_LOW = 1'b1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       slow_clk,
    input  logic       start,
    input  logic       pause,
    input  logic       load,
    input  logic [3:0] preset_tens,
    input  logic [3:0] preset_ones,
    output logic [3:0] tens,
    output logic [3:0] ones,
    output logic [6:0] seg_tens,
    output logic [6:0] seg_ones,
    output logic       running,
    output logic       done
);

    timer_state_t state;
    logic         slow_prev;
    logic         tick;
    logic         count_zero;
    logic         count_one;

    assign tick       = slow_clk & ~slow_prev;
    assign count_zero = (tens == 4'd0) && (ones == 4'd0);
    assign count_one  = (tens == 4'd0) && (ones == 4'd1);

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            tens      <= 4'd0;
            ones      <= 4'd0;
            slow_prev <= 1'b0;
            running   <= 1'b0;
            done      <= 1'b0;
        end else begin
            slow_prev <= slow_clk;
            case (state)
                IDLE: begin
                    if (load) begin
                        tens <= bcd_clamp(preset_tens);
                        ones <= bcd_clamp(preset_ones);
                    end else if (!pause && start && !count_zero) begin
                        state   <= RUN;
                        running <= 1'b1;
                    end
                end
                RUN: begin
                    // Pause wins over a coincident tick; load has no effect while running.
                    if (pause) begin
                        state   <= PAUSED;
                        running <= 1'b0;
                    end else if (tick && !count_zero) begin
                        if (ones != 4'd0) begin
                            ones <= ones - 4'd1;
                        end else begin
                            ones <= BCD_MAX;
                            tens <= tens - 4'd1;
                        end
                        if (count_one) begin
                            state   <= DONE;
                            running <= 1'b0;
                            done    <= 1'b1;
                        end
                    end
                end
                PAUSED: begin
                    if (load) begin
                        tens  <= bcd_clamp(preset_tens);
                        ones  <= bcd_clamp(preset_ones);
                        state <= IDLE;
                    end else if (!pause && start) begin
                        state   <= RUN;
                        running <= 1'b1;
                    end
                end
                DONE: begin
                    if (load) begin
                        tens  <= bcd_clamp(preset_tens);
                        ones  <= bcd_clamp(preset_ones);
                        state <= IDLE;
                        done  <= 1'b0;
                    end
                end
                default: begin
                    state   <= IDLE;
                    running <= 1'b0;
                    done    <= 1'b0;
                end
            endcase
        end
    end

    bcd_to_7seg #(
        .SEG_ACTIVE_LOW(SEG_ACTIVE_LOW)
    ) u_seg_tens (
        .bcd(tens),
        .seg(seg_tens)
    );

    bcd_to_7seg #(
        .SEG_ACTIVE_LOW(SEG_ACTIVE_LOW)
    ) u_seg_ones (
        .bcd(ones),
        .seg(seg_ones)
    );

endmodule

// File: tb/tb_tick_countdown_timer.sv
// Directed self-checking bench for tick_countdown_timer (active-low segments).
module tb_tick_countdown_timer;

    logic       clk;
    logic       reset;
    logic       slow_clk;
    logic       start;
    logic       pause;
    logic       load;
    logic [3:0] preset_tens;
    logic [3:0] preset_ones;
    logic [3:0] tens;
    logic [3:0] ones;
    logic [6:0] seg_tens;
    logic [6:0] seg_ones;
    logic       running;
    logic       done;

    int checks = 0;
    int errors = 0;

    tick_countdown_timer #(
        .SEG_ACTIVE_LOW(1'b1)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .slow_clk   (slow_clk),
        .start      (start),
        .pause      (pause),
        .load       (load),
        .preset_tens(preset_tens),
        .preset_ones(preset_ones),
        .tens       (tens),
        .ones       (ones),
        .seg_tens   (seg_tens),
        .seg_ones   (seg_ones),
        .running    (running),
        .done       (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one clock; inputs are driven and outputs sampled 1 ns after the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [7:0] observed,
                         input logic [7:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    task automatic check_count(input string tag, input logic [3:0] exp_tens,
                               input logic [3:0] exp_ones);
        check({tag, "_tens"}, {4'd0, tens}, {4'd0, exp_tens});
        check({tag, "_ones"}, {4'd0, ones}, {4'd0, exp_ones});
    endtask

    // One slow_clk period: high for one cycle, low for three.
    task automatic slow_pulse();
        slow_clk = 1'b1;
        step();
        slow_clk = 1'b0;
        step();
        step();
        step();
    endtask

    task automatic do_load(input logic [3:0] t, input logic [3:0] o);
        preset_tens = t;
        preset_ones = o;
        load = 1'b1;
        step();
        load = 1'b0;
    endtask

    task automatic do_start();
        start = 1'b1;
        step();
        start = 1'b0;
    endtask

    task automatic do_pause();
        pause = 1'b1;
        step();
        pause = 1'b0;
    endtask

    initial begin
        reset = 1'b1;
        slow_clk = 1'b0;
        start = 1'b0;
        pause = 1'b0;
        load = 1'b0;
        preset_tens = 4'd0;
        preset_ones = 4'd0;

        // 1 Reset
        step();
        step();
        reset = 1'b0;
        check_count("reset", 4'd0, 4'd0);
        check("reset_running", {7'd0, running}, 8'd0);
        check("reset_done", {7'd0, done}, 8'd0);
        check("reset_seg_tens", {1'b0, seg_tens}, {1'b0, 7'b1000000});
        check("reset_seg_ones", {1'b0, seg_ones}, {1'b0, 7'b1000000});

        // 2 Full run from 12
        do_load(4'd1, 4'd2);
        check_count("load12", 4'd1, 4'd2);
        check("load12_seg_tens", {1'b0, seg_tens}, {1'b0, 7'b1111001});
        check("load12_seg_ones", {1'b0, seg_ones}, {1'b0, 7'b0100100});
        check("load12_running", {7'd0, running}, 8'd0);
        do_start();
        check("start12_running", {7'd0, running}, 8'd1);
        for (int i = 1; i <= 12; i++) begin
            slow_pulse();
            check_count("run12", 4'((12 - i) / 10), 4'((12 - i) % 10));
            if (i == 11) check("run12_at01_running", {7'd0, running}, 8'd1);
        end
        check("run12_done", {7'd0, done}, 8'd1);
        check("run12_running", {7'd0, running}, 8'd0);
        do_start();
        step();
        check_count("done_start", 4'd0, 4'd0);
        check("done_start_done", {7'd0, done}, 8'd1);
        check("done_start_running", {7'd0, running}, 8'd0);

        // 3 Pause coincident with a tick
        do_load(4'd0, 4'd9);
        check("load09_done", {7'd0, done}, 8'd0);
        do_start();
        slow_pulse();
        slow_pulse();
        check_count("run_to07", 4'd0, 4'd7);
        slow_clk = 1'b1;
        pause = 1'b1;
        step();
        slow_clk = 1'b0;
        pause = 1'b0;
        check_count("pause_tick", 4'd0, 4'd7);
        check("pause_running", {7'd0, running}, 8'd0);
        check("pause_done", {7'd0, done}, 8'd0);
        slow_pulse();
        check_count("paused_tick_dropped", 4'd0, 4'd7);
        do_start();
        check("resume_running", {7'd0, running}, 8'd1);
        slow_pulse();
        check_count("resume_tick", 4'd0, 4'd6);
        check("seg_ones_6", {1'b0, seg_ones}, {1'b0, 7'b0000010});

        // 4 Load ignored in RUN, clamp, borrow
        do_load(4'hF, 4'hA);
        check_count("run_load_ignored", 4'd0, 4'd6);
        check("run_load_running", {7'd0, running}, 8'd1);
        do_pause();
        do_load(4'hF, 4'hA);
        check_count("clamp", 4'd9, 4'd9);
        check("clamp_running", {7'd0, running}, 8'd0);
        check("seg_tens_9", {1'b0, seg_tens}, {1'b0, 7'b0010000});
        do_start();
        slow_pulse();
        check_count("dec99", 4'd9, 4'd8);
        check("seg_ones_8", {1'b0, seg_ones}, {1'b0, 7'b0000000});
        do_pause();
        do_load(4'd1, 4'd0);
        check_count("load10", 4'd1, 4'd0);
        do_start();
        slow_pulse();
        check_count("borrow", 4'd0, 4'd9);

        // 5 Reset mid-run
        for (int i = 0; i < 4; i++) slow_pulse();
        check_count("run_to05", 4'd0, 4'd5);
        check("seg_ones_5", {1'b0, seg_ones}, {1'b0, 7'b0010010});
        reset = 1'b1;
        step();
        reset = 1'b0;
        check_count("mid_reset", 4'd0, 4'd0);
        check("mid_reset_running", {7'd0, running}, 8'd0);
        check("mid_reset_done", {7'd0, done}, 8'd0);
        slow_pulse();
        slow_pulse();
        check_count("post_reset_ticks", 4'd0, 4'd0);

        // Edge seen in IDLE must not be replayed once running
        do_load(4'd0, 4'd5);
        slow_pulse();
        do_start();
        step();
        step();
        check_count("idle_edge_dropped", 4'd0, 4'd5);

        // 6 Held-high slow_clk gives one decrement
        do_pause();
        do_load(4'd0, 4'd3);
        do_start();
        slow_clk = 1'b1;
        for (int i = 0; i < 20; i++) step();
        slow_clk = 1'b0;
        step();
        check_count("held_high", 4'd0, 4'd2);
        slow_pulse();
        slow_pulse();
        check_count("run_to00", 4'd0, 4'd0);
        check("run_to00_done", {7'd0, done}, 8'd1);
        do_load(4'd0, 4'd0);
        check("load00_done", {7'd0, done}, 8'd0);
        do_start();
        step();
        check("start00_running", {7'd0, running}, 8'd0);
        check("start00_done", {7'd0, done}, 8'd0);
        check_count("start00", 4'd0, 4'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
